// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults and the saturation helper used by the butterfly stages.
package fft_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned TW_W     = 12;
   localparam int unsigned TW_SHIFT = 7;
   localparam int unsigned TW_ROUND = 1 << (TW_SHIFT - 1);

   // True when v does not fit in a w-bit two's-complement value.
   function automatic logic sat_clips(input logic signed [63:0] v, input int unsigned w);
      logic signed [63:0] hi;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      return (v > hi) || (v < (-hi - 64'sd1));
   endfunction

endpackage

// File: rtl/fft_butterfly_4_if.sv
// Sample stream into and result stream out of the radix-2 butterfly, valid/ready on both sides.
interface fft_butterfly_4_if #(
   parameter int unsigned DATA_W = fft_pkg::DATA_W
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] a_re;
   logic signed [DATA_W-1:0] a_im;
   logic signed [DATA_W-1:0] b_re;
   logic signed [DATA_W-1:0] b_im;
   logic [2:0]               idx;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] y0_re;
   logic signed [DATA_W-1:0] y0_im;
   logic signed [DATA_W-1:0] y1_re;
   logic signed [DATA_W-1:0] y1_im;
   logic                     sat;

   modport slave (
      input  in_valid, a_re, a_im, b_re, b_im, idx, out_ready,
      output in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, sat
   );

   modport master (
      output in_valid, a_re, a_im, b_re, b_im, idx, out_ready,
      input  in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, sat
   );
endinterface

// File: rtl/fft_cmul.sv
// Registered full-precision complex multiply p = b * W, advancing only when en is high.
module fft_cmul #(
   parameter int unsigned DATA_W = fft_pkg::DATA_W,
   parameter int unsigned TW_W   = fft_pkg::TW_W
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic signed [DATA_W-1:0]        b_re,
   input  logic signed [DATA_W-1:0]        b_im,
   input  logic signed [TW_W-1:0]          tw_re,
   input  logic signed [TW_W-1:0]          tw_im,
   output logic signed [DATA_W+TW_W:0]     p_re,
   output logic signed [DATA_W+TW_W:0]     p_im
);
   localparam int unsigned P_W = DATA_W + TW_W + 1;

   logic signed [P_W-1:0] br, bi, wr, wi, nr, ni;

   always_comb begin
      br = P_W'(b_re);
      bi = P_W'(b_im);
      wr = P_W'(tw_re);
      wi = P_W'(tw_im);
      nr = br * wr - bi * wi;
      ni = br * wi + bi * wr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_re <= '0;
         p_im <= '0;
      end else if (en) begin
         p_re <= nr;
         p_im <= ni;
      end
   end
endmodule

// File: rtl/fft_butterfly_4.sv
// Three-stage radix-2 DIT butterfly: input register, complex multiply, round/add/saturate.
module fft_butterfly_4 #(
   parameter int unsigned DATA_W   = fft_pkg::DATA_W,
   parameter int unsigned TW_W     = fft_pkg::TW_W,
   parameter int unsigned TW_SHIFT = fft_pkg::TW_SHIFT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fft_butterfly_4_if.slave       bus,
   output logic [2:0]             tw_idx,
   input  logic signed [TW_W-1:0] tw_re,
   input  logic signed [TW_W-1:0] tw_im
);
   import fft_pkg::sat_clips;

   localparam int unsigned P_W = DATA_W + TW_W + 1;
   localparam int unsigned S_W = DATA_W + 2;
   localparam logic signed [P_W-1:0]    RND   = P_W'(1 << (TW_SHIFT - 1));
   localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic                     en, v0, v1, clip;
   logic signed [DATA_W-1:0] a0_re, a0_im, b0_re, b0_im, a1_re, a1_im;
   logic signed [P_W-1:0]    p_re, p_im;
   logic signed [S_W-1:0]    bw_re, bw_im, s0_re, s0_im, s1_re, s1_im;

   // A single enable for every stage: the whole pipe freezes while the output is held.
   assign en           = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = en;

   function automatic logic signed [DATA_W-1:0] clamp(input logic signed [S_W-1:0] s);
      if (!sat_clips(64'(s), DATA_W)) return s[DATA_W-1:0];
      return s[S_W-1] ? Y_MIN : Y_MAX;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0     <= 1'b0;
         tw_idx <= '0;
         a0_re  <= '0;
         a0_im  <= '0;
         b0_re  <= '0;
         b0_im  <= '0;
      end else if (en) begin
         v0 <= bus.in_valid;
         if (bus.in_valid) begin
            tw_idx <= bus.idx;
            a0_re  <= bus.a_re;
            a0_im  <= bus.a_im;
            b0_re  <= bus.b_re;
            b0_im  <= bus.b_im;
         end
      end
   end

   fft_cmul #(.DATA_W(DATA_W), .TW_W(TW_W)) u_cmul (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .b_re  (b0_re),
      .b_im  (b0_im),
      .tw_re (tw_re),
      .tw_im (tw_im),
      .p_re  (p_re),
      .p_im  (p_im)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         a1_re <= '0;
         a1_im <= '0;
      end else if (en) begin
         v1    <= v0;
         a1_re <= a0_re;
         a1_im <= a0_im;
      end
   end

   // Round half up, then drop the twiddle scale with an arithmetic shift.
   always_comb begin
      bw_re = S_W'((p_re + RND) >>> TW_SHIFT);
      bw_im = S_W'((p_im + RND) >>> TW_SHIFT);
      s0_re = S_W'(a1_re) + bw_re;
      s0_im = S_W'(a1_im) + bw_im;
      s1_re = S_W'(a1_re) - bw_re;
      s1_im = S_W'(a1_im) - bw_im;
      clip  = sat_clips(64'(s0_re), DATA_W) | sat_clips(64'(s0_im), DATA_W) |
              sat_clips(64'(s1_re), DATA_W) | sat_clips(64'(s1_im), DATA_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.y0_re     <= '0;
         bus.y0_im     <= '0;
         bus.y1_re     <= '0;
         bus.y1_im     <= '0;
         bus.sat       <= 1'b0;
      end else if (en) begin
         bus.out_valid <= v1;
         bus.y0_re     <= clamp(s0_re);
         bus.y0_im     <= clamp(s0_im);
         bus.y1_re     <= clamp(s1_re);
         bus.y1_im     <= clamp(s1_im);
         bus.sat       <= clip;
      end
   end
endmodule

// File: tb/tb_fft_butterfly_4.sv
// Directed bench for fft_butterfly_4 with an 8-entry twiddle ROM model on the tw_* side.
module tb_fft_butterfly_4;

   logic                clk;
   logic                rst_n;
   logic [2:0]          tw_idx;
   logic signed [11:0]  tw_re;
   logic signed [11:0]  tw_im;

   int checks = 0;
   int errors = 0;

   fft_butterfly_4_if bus ();

   fft_butterfly_4 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .tw_idx (tw_idx),
      .tw_re  (tw_re),
      .tw_im  (tw_im)
   );

   localparam int ROM_RE [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
   localparam int ROM_IM [8] = '{0, -90, -127, -90, 0, 90, 127, 90};

   always_comb begin
      tw_re = 12'(ROM_RE[tw_idx]);
      tw_im = 12'(ROM_IM[tw_idx]);
   end

   // a = (1000,-500), b = (200,100) through W[0..7]
   localparam int E0R [8] = '{1198, 1211, 1099, 930, 802, 789, 901, 1070};
   localparam int E0I [8] = '{-401, -570, -698, -711, -599, -430, -302, -289};
   localparam int E1R [8] = '{802, 789, 901, 1070, 1198, 1211, 1099, 930};
   localparam int E1I [8] = '{-599, -430, -302, -289, -401, -570, -698, -711};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int n);
      chk($sformatf("%s%0d_y0re", tag, n), bus.y0_re, E0R[n]);
      chk($sformatf("%s%0d_y0im", tag, n), bus.y0_im, E0I[n]);
      chk($sformatf("%s%0d_y1re", tag, n), bus.y1_re, E1R[n]);
      chk($sformatf("%s%0d_y1im", tag, n), bus.y1_im, E1I[n]);
      chk($sformatf("%s%0d_sat", tag, n), bus.sat, 0);
   endtask

   task automatic drive(input int k);
      bus.in_valid = 1'b1;
      bus.a_re     = 16'sd1000;
      bus.a_im     = -16'sd500;
      bus.b_re     = 16'sd200;
      bus.b_im     = 16'sd100;
      bus.idx      = 3'(k);
   endtask

   task automatic one(input string tag, input int ar, input int ai, input int br, input int bi,
                      input int ix, input int e0r, input int e0i, input int e1r, input int e1i,
                      input int es);
      int lat;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a_re     = 16'(ar);
      bus.a_im     = 16'(ai);
      bus.b_re     = 16'(br);
      bus.b_im     = 16'(bi);
      bus.idx      = 3'(ix);
      lat = 0;
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         lat++;
      end while (!bus.out_valid && lat < 10);
      chk({tag, "_lat"},  lat, 3);
      chk({tag, "_y0re"}, bus.y0_re, e0r);
      chk({tag, "_y0im"}, bus.y0_im, e0i);
      chk({tag, "_y1re"}, bus.y1_re, e1r);
      chk({tag, "_y1im"}, bus.y1_im, e1i);
      chk({tag, "_sat"},  bus.sat, es);
   endtask

   initial begin
      int n, first, stall, k;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a_re      = '0;
      bus.a_im      = '0;
      bus.b_re      = '0;
      bus.b_im      = '0;
      bus.idx       = '0;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready",  bus.in_ready, 1);
      chk("rst_tw_idx",    tw_idx, 0);
      chk("rst_y0re",      bus.y0_re, 0);
      chk("rst_y1im",      bus.y1_im, 0);
      chk("rst_sat",       bus.sat, 0);
      @(negedge clk);
      rst_n = 1'b1;

      one("basic", 1000, 0, 512, 0, 0, 1508, 0, 492, 0, 0);
      one("round", 0, 0, 512, 0, 2, 0, -508, 0, 508, 0);
      one("clip", 32000, 0, 32000, 0, 0, 32767, 0, 250, 0, 1);

      // back-to-back stream, idx 0..7, no backpressure
      n = 0;
      first = 0;
      for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (n == 0) first = cyc;
            else chk($sformatf("str%0d_slot", n), cyc, first + n);
            chk_out("str", n);
            n++;
         end
         if (cyc < 8) drive(cyc);
         else bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("str_count", n, 8);
      chk("str_lat", first, 3);

      // fill with out_ready low, hold 5 stalled cycles, then drain
      n = 0;
      stall = 0;
      k = 0;
      for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
         @(negedge clk);
         bus.out_ready = (stall >= 5);
         #1;
         if (bus.out_valid && !bus.out_ready) begin
            chk($sformatf("bp_stall%0d_in_ready", stall), bus.in_ready, 0);
            chk_out("bp_hold", 0);
            stall++;
         end else if (bus.out_valid) begin
            chk_out("bp", n);
            n++;
         end
         if (k < 8) begin
            drive(k);
            if (bus.in_ready) k++;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_count", n, 8);
      chk("bp_stalls", stall, 5);
      @(negedge clk);
      chk("bp_drained", bus.out_valid, 0);

      // reset with three samples in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(i);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("pre_rst_valid", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_y0re",      bus.y0_re, 0);
      chk("arst_y0im",      bus.y0_im, 0);
      chk("arst_y1re",      bus.y1_re, 0);
      chk("arst_y1im",      bus.y1_im, 0);
      chk("arst_sat",       bus.sat, 0);
      chk("arst_in_ready",  bus.in_ready, 1);
      chk("arst_tw_idx",    tw_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_quiet%0d", i), bus.out_valid, 0);
      end
      one("post_rst", 1000, 0, 512, 0, 0, 1508, 0, 492, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
